// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer: sweeps every input vector of a single-output gate,
// waits a programmable settle time per vector, captures the output into a
// truth table and compares it against an expected table.
module gate_truth_sequencer #(
  parameter int                    N_IN     = 2,
  parameter int                    SETTLE   = 1,
  parameter logic [2**N_IN-1:0]    EXPECTED = 4'b1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      vec,
  input  logic                 gate_s,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 pass,
  output logic [N_IN-1:0]      fail_idx
);

  localparam int NV = 2**N_IN;
  // Counter only needs to reach SETTLE-1; keep at least one bit.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  state_t            state, state_n;
  logic [N_IN-1:0]   vec_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [NV-1:0]     tbl_n;
  logic [NV-1:0]     diff;
  logic              pass_n;
  logic [N_IN-1:0]   fidx_n;

  // Next-state and next-datapath values; everything defaults to hold.
  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    tbl_n   = table_out;
    pass_n  = pass;
    fidx_n  = fail_idx;
    diff    = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_WAIT;
          vec_n   = '0;
          cnt_n   = '0;
          tbl_n   = '0;
          pass_n  = 1'b0;
          fidx_n  = '0;
        end
      end
      S_WAIT: begin
        if (cnt == CW'(SETTLE - 1)) state_n = S_SAMPLE;
        else                        cnt_n   = cnt + 1'b1;
      end
      S_SAMPLE: begin
        tbl_n[vec] = gate_s;
        if (vec == '1) begin
          // Verdict uses the table including the bit captured on this edge.
          state_n = S_DONE;
          diff    = tbl_n ^ EXPECTED;
          // An X in diff fails the if, so unknown captures read as a miss.
          if (diff == '0) pass_n = 1'b1;
          else            pass_n = 1'b0;
          fidx_n = '0;
          for (int i = NV - 1; i >= 0; i--)
            if (diff[i]) fidx_n = N_IN'(i);
        end else begin
          vec_n   = vec + 1'b1;
          cnt_n   = '0;
          state_n = S_WAIT;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State and all outputs are registered; busy/done follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      vec       <= '0;
      cnt       <= '0;
      table_out <= '0;
      pass      <= 1'b0;
      fail_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      vec       <= vec_n;
      cnt       <= cnt_n;
      table_out <= tbl_n;
      pass      <= pass_n;
      fail_idx  <= fidx_n;
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Bench for gate_truth_sequencer: two instances (SETTLE=1 and SETTLE=3),
// each driven by a table-lookup gate model; per-cycle traces are compared
// against the latency/result rules computed directly from the sweep rules.
module tb_gate_truth_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [1:0] v0, v1;
  logic       gs0, gs1;
  logic       b0, b1, d0, d1;
  logic [3:0] t0, t1;
  logic       p0, p1;
  logic [1:0] f0, f1;
  logic [3:0] gtab0, gtab1;

  int checks = 0;
  int errors = 0;

  // per-cycle traces of the instance under test; index = cycle after start
  logic [1:0] vtr [0:63];
  logic       dtr [0:63];
  logic       btr [0:63];
  logic [3:0] ttr [0:63];
  logic       ptr [0:63];
  logic [1:0] ftr [0:63];

  always #5 clk = ~clk;

  // gate under test: arbitrary truth table indexed by the input vector
  assign gs0 = gtab0[v0];
  assign gs1 = gtab1[v1];

  gate_truth_sequencer #(.N_IN(2), .SETTLE(1), .EXPECTED(4'b1000)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .vec(v0), .gate_s(gs0),
    .busy(b0), .done(d0), .table_out(t0), .pass(p0), .fail_idx(f0));

  gate_truth_sequencer #(.N_IN(2), .SETTLE(3), .EXPECTED(4'b1000)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .vec(v1), .gate_s(gs1),
    .busy(b1), .done(d1), .table_out(t1), .pass(p1), .fail_idx(f1));

  function automatic logic [1:0] first_diff(input logic [3:0] a, input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (a[i] != b[i]) return 2'(i);
    return 2'd0;
  endfunction

  // Start edge is edge 0; start stays high for edges < hold_n, plus edge poke;
  // rst is high for edge rst_at. Trace slot c is sampled after edge c-1.
  task automatic run(input int w, input int hold_n, input int poke,
                     input int rst_at, input int ncyc);
    logic s;
    @(negedge clk);
    if (w == 1) start1 = 1'b1; else start0 = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      vtr[c] = (w == 1) ? v1 : v0;
      dtr[c] = (w == 1) ? d1 : d0;
      btr[c] = (w == 1) ? b1 : b0;
      ttr[c] = (w == 1) ? t1 : t0;
      ptr[c] = (w == 1) ? p1 : p0;
      ftr[c] = (w == 1) ? f1 : f0;
      s = (c < hold_n) || (c == poke);
      if (w == 1) start1 = s; else start0 = s;
      rst = (c == rst_at);
    end
    start0 = 1'b0;
    start1 = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    gtab0 = 4'b1000; gtab1 = 4'b1000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({b0, d0, v0, t0, p0, f0} !== 11'd0) begin
      errors++; $display("FAIL reset0 got %b want 0", {b0, d0, v0, t0, p0, f0});
    end
    checks++;
    if ({b1, d1, v1, t1, p1, f1} !== 11'd0) begin
      errors++; $display("FAIL reset1 got %b want 0", {b1, d1, v1, t1, p1, f1});
    end
    rst = 1'b0;
  endtask

  task automatic test_and();
    int L;
    L = 4 * 2;
    gtab0 = 4'b1000;
    run(0, 1, 0, 0, 14);
    for (int c = 1; c <= 14; c++) begin
      checks++;
      if ({vtr[c], dtr[c], btr[c]} !== {2'((c <= L) ? (c - 1) / 2 : 3), c == L + 1, c <= L + 1}) begin
        errors++;
        $display("FAIL and_trace c=%0d got v=%0d d=%b b=%b", c, vtr[c], dtr[c], btr[c]);
      end
    end
    checks++;
    if ({ttr[L+1], ptr[L+1], ftr[L+1]} !== {4'b1000, 1'b1, 2'd0}) begin
      errors++; $display("FAIL and_result got t=%b p=%b f=%0d want 1000 1 0", ttr[L+1], ptr[L+1], ftr[L+1]);
    end
    checks++;
    if ({ttr[14], ptr[14], ftr[14]} !== {4'b1000, 1'b1, 2'd0}) begin
      errors++; $display("FAIL and_hold got t=%b p=%b f=%0d want 1000 1 0", ttr[14], ptr[14], ftr[14]);
    end
  endtask

  task automatic test_or();
    gtab0 = 4'b1110;
    run(0, 1, 0, 0, 12);
    checks++;
    if ({ttr[9], ptr[9], ftr[9], dtr[9]} !== {4'b1110, 1'b0, 2'd1, 1'b1}) begin
      errors++; $display("FAIL or_result got t=%b p=%b f=%0d d=%b want 1110 0 1 1", ttr[9], ptr[9], ftr[9], dtr[9]);
    end
    checks++;
    if ({btr[9], btr[10]} !== 2'b10) begin
      errors++; $display("FAIL or_busy_drop got %b want 10", {btr[9], btr[10]});
    end
  endtask

  task automatic test_restart_ignored();
    int nd;
    gtab0 = 4'b1000;
    run(0, 1, 3, 0, 20);
    nd = 0;
    for (int c = 1; c <= 20; c++) if (dtr[c]) nd++;
    checks++;
    if (nd != 1 || dtr[9] !== 1'b1 || ptr[9] !== 1'b1) begin
      errors++; $display("FAIL restart_ignored got dones=%0d d9=%b p=%b want 1 1 1", nd, dtr[9], ptr[9]);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    gtab0 = 4'b1111;
    run(0, 1, 0, 4, 20);
    checks++;
    if ({btr[5], vtr[5], ttr[5], ptr[5]} !== 8'd0) begin
      errors++; $display("FAIL rst_mid got b=%b v=%0d t=%b p=%b want 0", btr[5], vtr[5], ttr[5], ptr[5]);
    end
    nd = 0;
    for (int c = 1; c <= 20; c++) if (dtr[c]) nd++;
    checks++;
    if (nd != 0) begin
      errors++; $display("FAIL rst_mid_done got %0d want 0", nd);
    end
    gtab0 = 4'b1000;
    run(0, 1, 0, 0, 12);
    checks++;
    if ({dtr[9], ttr[9], ptr[9], btr[10]} !== {1'b1, 4'b1000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rst_mid_resweep got d=%b t=%b p=%b b10=%b", dtr[9], ttr[9], ptr[9], btr[10]);
    end
  endtask

  task automatic test_settle3();
    int L;
    L = 4 * 4;
    gtab1 = 4'b1000;
    run(1, 1, 0, 0, 22);
    for (int c = 1; c <= 22; c++) begin
      checks++;
      if ({vtr[c], dtr[c], btr[c]} !== {2'((c <= L) ? (c - 1) / 4 : 3), c == L + 1, c <= L + 1}) begin
        errors++;
        $display("FAIL settle3_trace c=%0d got v=%0d d=%b b=%b", c, vtr[c], dtr[c], btr[c]);
      end
    end
    checks++;
    if ({ttr[17], ptr[17], ftr[17]} !== {4'b1000, 1'b1, 2'd0}) begin
      errors++; $display("FAIL settle3_result got t=%b p=%b f=%0d", ttr[17], ptr[17], ftr[17]);
    end
  endtask

  task automatic test_back_to_back();
    int nd;
    gtab0 = 4'b1000;
    run(0, 25, 0, 0, 25);
    nd = 0;
    for (int c = 1; c <= 25; c++) if (dtr[c]) nd++;
    checks++;
    if (nd != 2 || dtr[9] !== 1'b1 || dtr[19] !== 1'b1) begin
      errors++; $display("FAIL b2b_done got n=%0d d9=%b d19=%b want 2 1 1", nd, dtr[9], dtr[19]);
    end
    checks++;
    if ({ptr[9], ptr[19], btr[10], btr[11]} !== 4'b1101) begin
      errors++; $display("FAIL b2b_pass_gap got %b want 1101", {ptr[9], ptr[19], btr[10], btr[11]});
    end
    // a third sweep was accepted at edge 20; let it drain
    repeat (15) @(posedge clk);
  endtask

  task automatic test_random();
    int w, S, L;
    logic [3:0] tab;
    for (int it = 0; it < 10; it++) begin
      w   = int'($urandom_range(0, 1));
      S   = (w == 1) ? 3 : 1;
      L   = 4 * (S + 1);
      tab = 4'($urandom);
      if (w == 1) gtab1 = tab; else gtab0 = tab;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run(w, 1, 0, 0, L + 3);
      for (int c = 1; c <= L + 3; c++) begin
        checks++;
        if ({vtr[c], dtr[c], btr[c]} !== {2'((c <= L) ? (c - 1) / (S + 1) : 3), c == L + 1, c <= L + 1}) begin
          errors++;
          $display("FAIL rand_trace it=%0d c=%0d got v=%0d d=%b b=%b", it, c, vtr[c], dtr[c], btr[c]);
        end
      end
      checks++;
      if ({ttr[L+1], ptr[L+1], ftr[L+1]} !== {tab, tab == 4'b1000, first_diff(tab, 4'b1000)}) begin
        errors++;
        $display("FAIL rand_result it=%0d got t=%b p=%b f=%0d want t=%b p=%b f=%0d", it,
                 ttr[L+1], ptr[L+1], ftr[L+1], tab, tab == 4'b1000, first_diff(tab, 4'b1000));
      end
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_or();
    test_restart_ignored();
    test_reset_mid();
    test_settle3();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
